// File: rtl/mult_unit.sv
// mult_unit: 32x32 radix-2 shift-add multiplier (mult/multu, two issue slots) -> Hi/Lo; ports clk, reset, MultStart/MultSgn, MultStart2/MultSgn2, SrcA/SrcB, SrcA2/SrcB2, Hi, Lo, MultBusy, MultDone
module mult_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        MultStart,
  input  logic        MultSgn,
  input  logic        MultStart2,
  input  logic        MultSgn2,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [31:0] SrcA2,
  input  logic [31:0] SrcB2,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        MultBusy,
  output logic        MultDone
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;
  state_t      state, state_n;
  logic [63:0] acc, mcand, prod;
  logic [31:0] mplier, sel_a, sel_b, mag_a, mag_b;
  logic [5:0]  cnt;
  logic        neg, sel_sgn, go;
  always_comb begin
    sel_a   = MultStart2 ? SrcA2 : SrcA;
    sel_b   = MultStart2 ? SrcB2 : SrcB;
    sel_sgn = MultStart2 ? MultSgn2 : MultSgn;
    go      = (state == IDLE) && (MultStart || MultStart2);
    mag_a   = (sel_sgn && sel_a[31]) ? -sel_a : sel_a;
    mag_b   = (sel_sgn && sel_b[31]) ? -sel_b : sel_b;
    prod    = neg ? -acc : acc;
    state_n = state;
    case (state)
      IDLE:    state_n = go ? RUN : IDLE;
      RUN:     state_n = (cnt == 6'd31) ? FIX : RUN;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
      MultDone <= 1'b0;
    end else begin
      state    <= state_n;
      MultDone <= (state == FIX);
      if (go) begin
        acc    <= '0;
        mcand  <= {32'd0, mag_b};
        mplier <= mag_a;
        cnt    <= '0;
        neg    <= sel_sgn & (sel_a[31] ^ sel_b[31]);
      end else if (state == RUN) begin
        acc    <= acc + (mplier[0] ? mcand : 64'd0);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 6'd1;
      end else if (state == FIX) begin
        {Hi, Lo} <= prod;
      end
    end
  end
  assign MultBusy = (state != IDLE);
endmodule
